// File: rtl/sram_bridge_pkg.sv
// sram_bridge_pkg
// Shared definitions for the SRAM bridge.
//   - state_e: controller state encoding.
//   - Helper functions that derive the beat count, byte-lane count,
//     byte-to-word address shift and beat counter width from the
//     core/SRAM widths.
package sram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    TURN   = 2'b10,
    ACK    = 2'b11
  } state_e;

  localparam int MAX_BEATS  = 8;
  localparam int MAX_WAIT   = 7;
  // Wide enough for WAIT_CYCLES up to MAX_WAIT.
  localparam int WAIT_CNT_W = 3;

  // Number of SRAM beats per core word.
  function automatic int calc_beats(input int data_w, input int sram_w);
    return data_w / sram_w;
  endfunction

  // Byte lanes per SRAM word (1 for x8, 2 for x16).
  function automatic int calc_lanes(input int sram_w);
    return sram_w / 8;
  endfunction

  // Right shift turning a byte address into an SRAM word address.
  function automatic int calc_lane_shift(input int sram_w);
    return (sram_w == 16) ? 1 : 0;
  endfunction

  // Beat counter width; never below one bit.
  function automatic int calc_beat_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// sram_beat_timer
// Counts wait cycles inside one SRAM beat and the beat index inside a
// transaction.
//   clk, reset   : clock and synchronous active-high reset
//   clear        : restart at beat 0, wait count 0 (transaction accepted)
//   count_en     : advance the wait count (controller in ACCESS)
//   beat_inc     : step to the next beat and restart the wait count
//   beat         : current beat index
//   beat_next    : beat index the counter takes on the next edge
//   last_cycle   : current cycle is the final cycle of this beat's access
//   last_beat    : current beat is the final beat of the transaction
module sram_beat_timer
  import sram_bridge_pkg::*;
#(
  parameter int BEATS       = 2,
  parameter int WAIT_CYCLES = 0,
  parameter int BEAT_W      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              count_en,
  input  logic              beat_inc,
  output logic [BEAT_W-1:0] beat,
  output logic [BEAT_W-1:0] beat_next,
  output logic              last_cycle,
  output logic              last_beat
);

  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;

  assign last_cycle = (wait_q == WAIT_CNT_W'(WAIT_CYCLES));
  assign last_beat  = (beat_q == BEAT_W'(BEATS - 1));
  assign beat       = beat_q;
  assign beat_next  = beat_d;

  // Next-count logic: clear wins over a beat step, which wins over waiting.
  always_comb begin
    wait_d = wait_q;
    beat_d = beat_q;
    if (clear) begin
      wait_d = '0;
      beat_d = '0;
    end else if (beat_inc) begin
      wait_d = '0;
      beat_d = beat_q + BEAT_W'(1);
    end else if (count_en && !last_cycle) begin
      wait_d = wait_q + WAIT_CNT_W'(1);
    end else begin
      wait_d = wait_q;
      beat_d = beat_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= '0;
      beat_q <= '0;
    end else begin
      wait_q <= wait_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/sram_bridge.sv
// sram_bridge
// Bridges a single-word core request (read or byte-masked write) onto an
// asynchronous SRAM that is narrower than the core word, splitting the
// access into BEATS consecutive SRAM word accesses.
//   clk, reset       : clock, synchronous active-high reset
//   mem_read/write   : request strobes, only looked at in IDLE
//   mem_addr         : byte address of the core word
//   mem_write_data   : write data, mem_byte_en: write byte enables
//   mem_ack          : one-cycle completion pulse
//   mem_read_data    : assembled read word, held until the next request
//   busy             : controller not in IDLE
//   sram_*           : SRAM address, bidirectional data and active-low
//                      chip/output/write enables and byte lanes
// All outputs are registered: they are decoded from the next state so that
// they line up exactly with the state they describe.
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SRAM_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           mem_addr,
  input  logic [DATA_W-1:0]     mem_write_data,
  input  logic [DATA_W/8-1:0]   mem_byte_en,
  output logic                  mem_ack,
  output logic [DATA_W-1:0]     mem_read_data,
  output logic                  busy,
  output logic [ADDR_W-1:0]     sram_addr,
  inout  wire  [SRAM_W-1:0]     sram_dq,
  output logic                  sram_we_n,
  output logic                  sram_oe_n,
  output logic                  sram_ce_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n
);

  localparam int BEATS      = calc_beats(DATA_W, SRAM_W);
  localparam int LANES      = calc_lanes(SRAM_W);
  localparam int LANE_SHIFT = calc_lane_shift(SRAM_W);
  localparam int BEAT_W     = calc_beat_w(BEATS);
  localparam int BE_W       = DATA_W / 8;

  // Controller state and latched request.
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                is_wr_q, is_wr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // Registered outputs.
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                ce_n_q, ce_n_d;
  logic                ub_n_q, ub_n_d;
  logic                lb_n_q, lb_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic [SRAM_W-1:0]   dq_out_q, dq_out_d;

  // Timer handshake.
  logic                clear, count_en, beat_inc;
  logic [BEAT_W-1:0]   beat, beat_next;
  logic                last_cycle, last_beat;

  // Byte address to SRAM word address.
  logic [31:0]         addr_shift;
  logic [ADDR_W-1:0]   addr_word;
  logic                unused_addr_bits;

  // Slice offsets for the current and next beat.
  int                  rd_lsb, wr_lsb, be_lsb;
  logic                active_d;
  logic [LANES-1:0]    lane_be;

  assign addr_shift       = mem_addr >> LANE_SHIFT;
  assign addr_word        = addr_shift[ADDR_W-1:0];
  assign unused_addr_bits = ^addr_shift;

  assign rd_lsb = int'(beat) * SRAM_W;
  assign wr_lsb = int'(beat_next) * SRAM_W;
  assign be_lsb = int'(beat_next) * LANES;

  sram_beat_timer #(
    .BEATS       (BEATS),
    .WAIT_CYCLES (WAIT_CYCLES),
    .BEAT_W      (BEAT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .count_en   (count_en),
    .beat_inc   (beat_inc),
    .beat       (beat),
    .beat_next  (beat_next),
    .last_cycle (last_cycle),
    .last_beat  (last_beat)
  );

  // Next-state logic, request latching and read-data capture.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    is_wr_d  = is_wr_q;
    rdata_d  = rdata_q;
    clear    = 1'b0;
    count_en = 1'b0;
    beat_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          base_d  = addr_word;
          wdata_d = mem_write_data;
          be_d    = mem_byte_en;
          // A simultaneous read and write is served as a read.
          is_wr_d = !mem_read;
          clear   = 1'b1;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        count_en = 1'b1;
        if (last_cycle) begin
          if (is_wr_q) begin
            state_d = TURN;
          end else begin
            rdata_d[rd_lsb +: SRAM_W] = sram_dq;
            if (last_beat) begin
              state_d = ACK;
            end else begin
              beat_inc = 1'b1;
              state_d  = ACCESS;
            end
          end
        end else begin
          state_d = ACCESS;
        end
      end
      TURN: begin
        if (last_beat) begin
          state_d = ACK;
        end else begin
          beat_inc = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACK: begin
        // Requests seen here are dropped on purpose.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered pins match it.
  always_comb begin
    active_d = (state_d == ACCESS) || (state_d == TURN);
    lane_be  = be_d[be_lsb +: LANES];
    ack_d    = (state_d == ACK);
    busy_d   = (state_d != IDLE);
    ce_n_d   = !active_d;
    oe_n_d   = !((state_d == ACCESS) && !is_wr_d);
    // No write strobe for a beat whose byte enables are all clear.
    we_n_d   = !((state_d == ACCESS) && is_wr_d && (|lane_be));
    dq_oe_d  = active_d && is_wr_d;
    dq_out_d = wdata_d[wr_lsb +: SRAM_W];
    if (active_d) begin
      addr_d = base_d + ADDR_W'(beat_next);
    end else begin
      addr_d = '0;
    end
    if (active_d && is_wr_d) begin
      lb_n_d = ~lane_be[0];
      ub_n_d = (LANES == 2) ? ~lane_be[LANES-1] : 1'b1;
    end else if (active_d) begin
      lb_n_d = 1'b0;
      ub_n_d = (LANES == 2) ? 1'b0 : 1'b1;
    end else begin
      lb_n_d = 1'b1;
      ub_n_d = 1'b1;
    end
  end

  // State, request and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      is_wr_q  <= 1'b0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      ce_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      is_wr_q  <= is_wr_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      ce_n_q   <= ce_n_d;
      ub_n_q   <= ub_n_d;
      lb_n_q   <= lb_n_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
    end
  end

  assign sram_dq       = dq_oe_q ? dq_out_q : {SRAM_W{1'bz}};
  assign mem_ack       = ack_q;
  assign mem_read_data = rdata_q;
  assign busy          = busy_q;
  assign sram_addr     = addr_q;
  assign sram_we_n     = we_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_ub_n     = ub_n_q;
  assign sram_lb_n     = lb_n_q;

endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge
// Two bridges: dut_a (32/16, WAIT_CYCLES=1) and dut_b (32/16, WAIT_CYCLES=0),
// each with a small x16 SRAM model. Requests are steered to one of them by
// sel_b; the selected outputs are observed through the o_* signals.
module tb_sram_bridge;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_read, mem_write, sel_b;
  logic [31:0] mem_addr, wdata;
  logic [3:0]  be;

  logic        ack_a, busy_a, we_a, oe_a, ce_a, ub_a, lb_a;
  logic [31:0] rd_a;
  logic [19:0] addr_a;
  wire  [15:0] dq_a;
  logic        ack_b, busy_b, we_b, oe_b, ce_b, ub_b, lb_b;
  logic [31:0] rd_b;
  logic [19:0] addr_b;
  wire  [15:0] dq_b;

  logic        rd_a_s, wr_a_s, rd_b_s, wr_b_s;
  assign rd_a_s = mem_read  && !sel_b;
  assign wr_a_s = mem_write && !sel_b;
  assign rd_b_s = mem_read  && sel_b;
  assign wr_b_s = mem_write && sel_b;

  sram_bridge #(.DATA_W(32), .SRAM_W(16), .ADDR_W(20), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .mem_read(rd_a_s), .mem_write(wr_a_s),
    .mem_addr(mem_addr), .mem_write_data(wdata), .mem_byte_en(be),
    .mem_ack(ack_a), .mem_read_data(rd_a), .busy(busy_a),
    .sram_addr(addr_a), .sram_dq(dq_a), .sram_we_n(we_a), .sram_oe_n(oe_a),
    .sram_ce_n(ce_a), .sram_ub_n(ub_a), .sram_lb_n(lb_a)
  );

  sram_bridge #(.DATA_W(32), .SRAM_W(16), .ADDR_W(20), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .mem_read(rd_b_s), .mem_write(wr_b_s),
    .mem_addr(mem_addr), .mem_write_data(wdata), .mem_byte_en(be),
    .mem_ack(ack_b), .mem_read_data(rd_b), .busy(busy_b),
    .sram_addr(addr_b), .sram_dq(dq_b), .sram_we_n(we_b), .sram_oe_n(oe_b),
    .sram_ce_n(ce_b), .sram_ub_n(ub_b), .sram_lb_n(lb_b)
  );

  // SRAM models (low 8 address bits are enough for the words used here).
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic        pl_en, pl_b;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  assign dq_a = (!oe_a && !ce_a) ? mem_a[addr_a[7:0]] : 16'hzzzz;
  assign dq_b = (!oe_b && !ce_b) ? mem_b[addr_b[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (pl_en && !pl_b) mem_a[pl_addr] <= pl_data;
    else if (!ce_a && !we_a) begin
      if (!lb_a) mem_a[addr_a[7:0]][7:0]  <= dq_a[7:0];
      if (!ub_a) mem_a[addr_a[7:0]][15:8] <= dq_a[15:8];
    end
  end

  always @(posedge clk) begin
    if (pl_en && pl_b) mem_b[pl_addr] <= pl_data;
    else if (!ce_b && !we_b) begin
      if (!lb_b) mem_b[addr_b[7:0]][7:0]  <= dq_b[7:0];
      if (!ub_b) mem_b[addr_b[7:0]][15:8] <= dq_b[15:8];
    end
  end

  // Observed outputs of the selected bridge.
  logic        o_ack, o_busy, o_we, o_oe, o_ce, o_ub, o_lb;
  logic [31:0] o_rdata;
  logic [19:0] o_addr;
  assign o_ack   = sel_b ? ack_b  : ack_a;
  assign o_busy  = sel_b ? busy_b : busy_a;
  assign o_we    = sel_b ? we_b   : we_a;
  assign o_oe    = sel_b ? oe_b   : oe_a;
  assign o_ce    = sel_b ? ce_b   : ce_a;
  assign o_ub    = sel_b ? ub_b   : ub_a;
  assign o_lb    = sel_b ? lb_b   : lb_a;
  assign o_rdata = sel_b ? rd_b   : rd_a;
  assign o_addr  = sel_b ? addr_b : addr_a;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Per-request observations.
  logic [19:0] addr_log[$];
  int          we_cycles, we_pulses, ack_cnt, got_lat;
  logic [31:0] got_data;
  logic [19:0] we_addr;
  logic        we_lb, we_ub;

  task automatic preload(input logic b, input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_b = b; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drive one request for a single cycle and record what the SRAM side does
  // until a few cycles past the acknowledge (or the budget runs out).
  task automatic run_req(input logic b, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] bev, input int budget);
    int   t0;
    logic prev_we;
    addr_log.delete();
    we_cycles = 0; we_pulses = 0; ack_cnt = 0; got_lat = -1;
    got_data = 32'h0; we_addr = 20'h0; we_lb = 1'b1; we_ub = 1'b1;
    @(negedge clk);
    sel_b = b; mem_read = rd; mem_write = wr; mem_addr = a; wdata = wd; be = bev;
    t0 = cyc;
    prev_we = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (i == 1) begin
        mem_read = 1'b0; mem_write = 1'b0;
      end
      if (!o_ce && (addr_log.size() == 0 || addr_log[$] != o_addr))
        addr_log.push_back(o_addr);
      if (!o_we) begin
        we_cycles++;
        if (prev_we) we_pulses++;
        we_addr = o_addr; we_lb = o_lb; we_ub = o_ub;
      end
      prev_we = o_we;
      if (o_ack) begin
        ack_cnt++;
        if (got_lat < 0) begin
          got_lat  = cyc - t0;
          got_data = o_rdata;
        end
      end
      if (got_lat >= 0 && i >= got_lat + 3) break;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", ack_a); end
    total++; if (rd_a !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rd_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_a); end
    total++; if (addr_a !== 20'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", addr_a); end
    total++; if (ce_a !== 1'b1) begin bad++; $display("FAIL rst_ce got=%b exp=1", ce_a); end
    total++; if (oe_a !== 1'b1) begin bad++; $display("FAIL rst_oe got=%b exp=1", oe_a); end
    total++; if (we_a !== 1'b1) begin bad++; $display("FAIL rst_we got=%b exp=1", we_a); end
    total++; if ({ub_a, lb_a} !== 2'b11) begin bad++; $display("FAIL rst_lanes got=%b exp=11", {ub_a, lb_a}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read;
    exp_t e;
    preload(1'b0, 8'h08, 16'h1234);
    preload(1'b0, 8'h09, 16'hABCD);
    sb.push_back('{data: 32'hABCD1234, lat: 5});
    run_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 30);
    e = sb.pop_front();
    total++; if (got_data !== e.data) begin bad++; $display("FAIL read_data got=%h exp=%h", got_data, e.data); end
    total++; if (got_lat !== e.lat) begin bad++; $display("FAIL read_lat got=%0d exp=%0d", got_lat, e.lat); end
    total++; if (addr_log.size() !== 2) begin bad++; $display("FAIL read_nbeats got=%0d exp=2", addr_log.size()); end
    else begin
      total++; if (addr_log[0] !== 20'h00008) begin bad++; $display("FAIL read_addr0 got=%h exp=00008", addr_log[0]); end
      total++; if (addr_log[1] !== 20'h00009) begin bad++; $display("FAIL read_addr1 got=%h exp=00009", addr_log[1]); end
    end
    total++; if (we_cycles !== 0) begin bad++; $display("FAIL read_we got=%0d exp=0", we_cycles); end
    total++; if (ack_cnt !== 1) begin bad++; $display("FAIL read_acks got=%0d exp=1", ack_cnt); end
  endtask

  task automatic test_write_full;
    exp_t e;
    sb.push_back('{data: 32'h0, lat: 7});
    run_req(1'b0, 1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 4'b1111, 30);
    e = sb.pop_front();
    total++; if (got_lat !== e.lat) begin bad++; $display("FAIL wr_lat got=%0d exp=%0d", got_lat, e.lat); end
    total++; if (mem_a[8'h10] !== 16'hBEEF) begin bad++; $display("FAIL wr_word10 got=%h exp=beef", mem_a[8'h10]); end
    total++; if (mem_a[8'h11] !== 16'hDEAD) begin bad++; $display("FAIL wr_word11 got=%h exp=dead", mem_a[8'h11]); end
    total++; if (we_cycles !== 4) begin bad++; $display("FAIL wr_we_cycles got=%0d exp=4", we_cycles); end
    total++; if (we_pulses !== 2) begin bad++; $display("FAIL wr_we_pulses got=%0d exp=2", we_pulses); end
    total++; if (ack_cnt !== 1) begin bad++; $display("FAIL wr_acks got=%0d exp=1", ack_cnt); end
  endtask

  task automatic test_write_partial;
    exp_t e;
    preload(1'b0, 8'h10, 16'hAAAA);
    preload(1'b0, 8'h11, 16'h5555);
    sb.push_back('{data: 32'h0, lat: 7});
    run_req(1'b0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'b0100, 30);
    e = sb.pop_front();
    total++; if (got_lat !== e.lat) begin bad++; $display("FAIL pw_lat got=%0d exp=%0d", got_lat, e.lat); end
    total++; if (mem_a[8'h10] !== 16'hAAAA) begin bad++; $display("FAIL pw_word10 got=%h exp=aaaa", mem_a[8'h10]); end
    total++; if (mem_a[8'h11] !== 16'h5522) begin bad++; $display("FAIL pw_word11 got=%h exp=5522", mem_a[8'h11]); end
    total++; if (we_pulses !== 1) begin bad++; $display("FAIL pw_pulses got=%0d exp=1", we_pulses); end
    total++; if (we_addr !== 20'h00011) begin bad++; $display("FAIL pw_we_addr got=%h exp=00011", we_addr); end
    total++; if ({we_ub, we_lb} !== 2'b10) begin bad++; $display("FAIL pw_lanes got=%b exp=10", {we_ub, we_lb}); end
  endtask

  task automatic test_write_zero_be;
    exp_t e;
    sb.push_back('{data: 32'h0, lat: 7});
    run_req(1'b0, 1'b0, 1'b1, 32'h20, 32'h0F0F0F0F, 4'b0000, 30);
    e = sb.pop_front();
    total++; if (got_lat !== e.lat) begin bad++; $display("FAIL zbe_lat got=%0d exp=%0d", got_lat, e.lat); end
    total++; if (we_cycles !== 0) begin bad++; $display("FAIL zbe_we got=%0d exp=0", we_cycles); end
    total++; if ({mem_a[8'h11], mem_a[8'h10]} !== 32'h5522AAAA) begin bad++; $display("FAIL zbe_mem got=%h exp=5522aaaa", {mem_a[8'h11], mem_a[8'h10]}); end
    total++; if (addr_log.size() !== 2) begin bad++; $display("FAIL zbe_nbeats got=%0d exp=2", addr_log.size()); end
  endtask

  task automatic test_read_write_both;
    exp_t e;
    sb.push_back('{data: 32'hABCD1234, lat: 5});
    run_req(1'b0, 1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b1111, 30);
    e = sb.pop_front();
    total++; if (got_data !== e.data) begin bad++; $display("FAIL rw_data got=%h exp=%h", got_data, e.data); end
    total++; if (got_lat !== e.lat) begin bad++; $display("FAIL rw_lat got=%0d exp=%0d", got_lat, e.lat); end
    total++; if ({mem_a[8'h09], mem_a[8'h08]} !== 32'hABCD1234) begin bad++; $display("FAIL rw_mem got=%h exp=abcd1234", {mem_a[8'h09], mem_a[8'h08]}); end
    total++; if (ack_cnt !== 1) begin bad++; $display("FAIL rw_acks got=%0d exp=1", ack_cnt); end
    total++; if (we_cycles !== 0) begin bad++; $display("FAIL rw_we got=%0d exp=0", we_cycles); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int   acks;
    @(negedge clk);
    sel_b = 1'b0; mem_write = 1'b1; mem_read = 1'b0;
    mem_addr = 32'h20; wdata = 32'hCAFEF00D; be = 4'b1111;
    @(negedge clk);
    mem_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy_a); end
    total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL mid_ack got=%b exp=0", ack_a); end
    total++; if ({ce_a, oe_a, we_a} !== 3'b111) begin bad++; $display("FAIL mid_strobes got=%b exp=111", {ce_a, oe_a, we_a}); end
    total++; if (addr_a !== 20'h0) begin bad++; $display("FAIL mid_addr got=%h exp=0", addr_a); end
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack_a) acks++;
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL mid_late_ack got=%0d exp=0", acks); end
    sb.push_back('{data: 32'hABCD1234, lat: 5});
    run_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 30);
    e = sb.pop_front();
    total++; if (got_data !== e.data) begin bad++; $display("FAIL mid_read_data got=%h exp=%h", got_data, e.data); end
    total++; if (got_lat !== e.lat) begin bad++; $display("FAIL mid_read_lat got=%0d exp=%0d", got_lat, e.lat); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic seen;
    preload(1'b0, 8'h20, 16'h1111);
    preload(1'b0, 8'h21, 16'h2222);
    sb.push_back('{data: 32'h22221111, lat: 5});
    @(negedge clk);
    sel_b = 1'b0; mem_read = 1'b1; mem_write = 1'b0; mem_addr = 32'h40;
    seen = 1'b0;
    for (int i = 1; i <= 30 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) mem_read = 1'b0;
      if (ack_a) begin
        seen = 1'b1;
        e = sb.pop_front();
        total++; if (rd_a !== e.data) begin bad++; $display("FAIL b2b_data got=%h exp=%h", rd_a, e.data); end
        total++; if (i !== e.lat) begin bad++; $display("FAIL b2b_lat got=%0d exp=%0d", i, e.lat); end
        // A write presented only during ACK must be dropped.
        mem_write = 1'b1; wdata = 32'h0; be = 4'b1111;
      end
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL b2b_timeout got=%b exp=1", seen); end
    @(negedge clk);
    mem_write = 1'b0;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", busy_a); end
    @(negedge clk);
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL b2b_ignored got=%b exp=0", busy_a); end
    total++; if (mem_a[8'h20] !== 16'h1111) begin bad++; $display("FAIL b2b_mem got=%h exp=1111", mem_a[8'h20]); end
    sb.push_back('{data: 32'hABCD1234, lat: 5});
    run_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 30);
    e = sb.pop_front();
    total++; if (got_data !== e.data) begin bad++; $display("FAIL b2b_second got=%h exp=%h", got_data, e.data); end
  endtask

  task automatic test_wrap;
    exp_t e;
    preload(1'b1, 8'hFF, 16'h5678);
    preload(1'b1, 8'h00, 16'h9ABC);
    sb.push_back('{data: 32'h9ABC5678, lat: 3});
    run_req(1'b1, 1'b1, 1'b0, 32'h001FFFFE, 32'h0, 4'h0, 30);
    e = sb.pop_front();
    total++; if (got_data !== e.data) begin bad++; $display("FAIL wrap_data got=%h exp=%h", got_data, e.data); end
    total++; if (got_lat !== e.lat) begin bad++; $display("FAIL wrap_lat got=%0d exp=%0d", got_lat, e.lat); end
    total++; if (addr_log.size() !== 2) begin bad++; $display("FAIL wrap_nbeats got=%0d exp=2", addr_log.size()); end
    else begin
      total++; if (addr_log[0] !== 20'hFFFFF) begin bad++; $display("FAIL wrap_addr0 got=%h exp=fffff", addr_log[0]); end
      total++; if (addr_log[1] !== 20'h00000) begin bad++; $display("FAIL wrap_addr1 got=%h exp=00000", addr_log[1]); end
    end
    sel_b = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; sel_b = 1'b0;
    mem_addr = 32'h0; wdata = 32'h0; be = 4'h0;
    pl_en = 1'b0; pl_b = 1'b0; pl_addr = 8'h0; pl_data = 16'h0;
    test_reset();
    test_read();
    test_write_full();
    test_write_partial();
    test_write_zero_be();
    test_read_write_both();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
